ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction fetch stage that produces the instruction/PC pair consumed by the decode stage through the IF/ID boundary.
- Owns the architectural fetch PC and issues sequential requests to instruction memory.
- Buffers in-order responses in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects (branch/jump) from execute; all stale in-flight responses are discarded using an epoch bit.

Parameters:
- PC_WIDTH, 32, fetch PC / memory address width
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 32'h8000_0000, first fetch address after reset
- FIFO_DEPTH, 2, instruction buffer entries; also the in-flight request limit; power of 2, minimum 2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PC_WIDTH  fetch address, word aligned
- imem_rsp_valid  in  1  response valid; no backpressure, in request order
- imem_rsp_data  in  INSTR_WIDTH  fetched instruction
- imem_rsp_err  in  1  access fault for this response
- if_valid_o  out  1  instruction available to decode
- if_ready_i  in  1  decode accepts instruction
- if_instr_o  out  INSTR_WIDTH  instruction to decode
- if_pc_o  out  PC_WIDTH  PC of if_instr_o
- if_err_o  out  1  fetch fault flag for this entry
- redirect_valid_i  in  1  redirect request from execute
- redirect_pc_i  in  PC_WIDTH  redirect target

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - fetch_pc = RESET_PC; epoch = 0
  - in-flight queue and FIFO empty
  - imem_req_valid = 0, if_valid_o = 0, if_instr_o = 0, if_pc_o = 0, if_err_o = 0
- First request is issued in the first cycle after rst_n deasserts.
- Request issue:
  - imem_req_valid = !redirect_valid_i && (inflight_cnt + fifo_cnt - pop) < FIFO_DEPTH, where pop = if_valid_o & if_ready_i.
  - imem_req_addr = fetch_pc.
  - imem_req_valid may drop without acceptance; memory must tolerate this.
- On accept (valid & ready):
  - push {fetch_pc, epoch} into the in-flight queue.
  - fetch_pc += 4, wrapping modulo 2^PC_WIDTH.
- Credit rule guarantees every response has a FIFO slot, so imem_rsp has no ready.
- Response handling:
  - A response pops the in-flight head.
  - If the head epoch equals the current epoch and there is no redirect this cycle, push {data, pc, err} into the FIFO.
  - Otherwise drop the response; the in-flight count still decrements.
  - A response with an empty in-flight queue (e.g. arriving after reset) is ignored.
- Fault: when err=1, the FIFO entry carries instr = 32'h0000_0013 (NOP) and err = 1.
- Output:
  - if_valid_o = FIFO non-empty; if_instr_o, if_pc_o and if_err_o come from the FIFO head register.
  - Outputs are held stable while if_valid_o & !if_ready_i.
- Latency: request accepted at cycle N, response at N+k → if_valid_o at N+k+1 (registered FIFO).
- Throughput: 1 instruction/cycle with a 1-cycle memory and decode always ready.
- Redirect (redirect_valid_i = 1), effective at the next edge:
  - fetch_pc = {redirect_pc_i[PC_WIDTH-1:2], 2'b00}
  - epoch toggles
  - FIFO flushed
  - imem_req_valid forced 0 in the redirect cycle
  - first new request issued in the following cycle
- Simultaneous events:
  - redirect + response → response dropped.
  - redirect + decode pop → flush wins; the popped entry counts as consumed.
  - response + pop on a full FIFO → both proceed; count unchanged.
  - back-to-back redirects → last one wins.
  - redirect with empty in-flight queue → only PC, epoch and FIFO are updated.
- FIFO full and in-flight full → no request issued; the PC is held.

Optional Feature:
- Macro: IFETCH_JAL_PREDECODE_EN.
- When defined:
  - An accepted, current-epoch response with opcode 7'b1101111 (JAL) and no error triggers an internal redirect to pc + sign-extended J-immediate.
  - That redirect toggles the epoch and drops younger in-flight responses.
  - It does NOT flush the FIFO; the JAL itself is still enqueued.
  - An external redirect in the same cycle takes priority.
- When undefined: JAL is fetched sequentially like any other instruction.

Test Plan:
- Reset release, 1-cycle memory, decode always ready → requests to 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; if_pc_o increments by 4 each cycle from the 2nd cycle after the first request.
- Decode holds if_ready_i=0 for 5 cycles → at most 2 outstanding plus buffered; if_instr_o/if_pc_o stable; no lost or duplicated PC after release.
- Redirect to 0x80000102 with 2 responses in flight → both dropped; next request address 0x80000100; first if_pc_o after the redirect = 0x80000100.
- imem_rsp_err=1 on PC 0x80000008 → if_instr_o=0x00000013, if_err_o=1 for that PC only.
- rst_n asserted mid-stream with 2 in flight → all outputs 0 immediately; after release, fetch restarts at 0x80000000 and late stray responses are ignored.
- With IFETCH_JAL_PREDECODE_EN: JAL x0,+16 at 0x80000000 → next enqueued PC after 0x80000000 is 0x80000010; sequential PCs in flight are discarded.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited memory requests and buffers responses for decode.
// Optional JAL predecode redirect is compiled in when IFETCH_JAL_PREDECODE_EN is defined.
module ifetch_unit #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h8000_0000,
    parameter int                  FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   imem_rsp_err,
    output logic                   if_valid_o,
    input  logic                   if_ready_i,
    output logic [INSTR_WIDTH-1:0] if_instr_o,
    output logic [PC_WIDTH-1:0]    if_pc_o,
    output logic                   if_err_o,
    input  logic                   redirect_valid_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

    logic [PC_WIDTH-1:0]    fetch_pc;
    logic                   epoch;

    logic [PC_WIDTH-1:0]    ifl_pc [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  ifl_ep;
    logic [FIFO_DEPTH-1:0]  ifl_live;
    logic [PW-1:0]          ifl_wr;
    logic [PW-1:0]          ifl_rd;
    logic [CW-1:0]          ifl_cnt;

    logic [INSTR_WIDTH-1:0] buf_instr [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]    buf_pc [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  buf_err;
    logic [PW-1:0]          buf_wr;
    logic [PW-1:0]          buf_rd;
    logic [CW-1:0]          buf_cnt;

    logic                   pop;
    logic                   accept;
    logic                   rsp_take;
    logic                   rsp_keep;
    logic                   kill;
    logic                   jal_hit;
    logic [PC_WIDTH-1:0]    head_pc;
    logic [PC_WIDTH-1:0]    jal_target;
    logic [PC_WIDTH-1:0]    redirect_aligned;
    logic [CW:0]            credit_used;

    // A request is only issued when its response is guaranteed a buffer slot
    assign pop              = (buf_cnt != '0) && if_ready_i;
    assign credit_used      = {1'b0, ifl_cnt} + {1'b0, buf_cnt} - {{CW{1'b0}}, pop};
    assign imem_req_valid   = rst_n && !redirect_valid_i && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr    = fetch_pc;
    assign accept           = imem_req_valid && imem_req_ready;

    assign head_pc          = ifl_pc[ifl_rd];
    assign rsp_take         = imem_rsp_valid && (ifl_cnt != '0);
    assign rsp_keep         = rsp_take && ifl_live[ifl_rd] && (ifl_ep[ifl_rd] == epoch) && !redirect_valid_i;
    assign redirect_aligned = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};

`ifdef IFETCH_JAL_PREDECODE_EN
    assign jal_hit    = rsp_keep && !imem_rsp_err && (imem_rsp_data[6:0] == 7'b1101111);
    assign jal_target = head_pc + {{(PC_WIDTH-20){imem_rsp_data[31]}}, imem_rsp_data[19:12],
                                   imem_rsp_data[20], imem_rsp_data[30:21], 1'b0};
`else
    assign jal_hit    = 1'b0;
    assign jal_target = '0;
`endif

    assign kill       = redirect_valid_i || jal_hit;

    assign if_valid_o = (buf_cnt != '0);
    assign if_instr_o = buf_instr[buf_rd];
    assign if_pc_o    = buf_pc[buf_rd];
    assign if_err_o   = buf_err[buf_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            epoch    <= 1'b0;
        end else if (redirect_valid_i) begin
            fetch_pc <= redirect_aligned;
            epoch    <= ~epoch;
        end else if (jal_hit) begin
            fetch_pc <= {jal_target[PC_WIDTH-1:2], 2'b00};
            epoch    <= ~epoch;
        end else if (accept) begin
            fetch_pc <= fetch_pc + PC_WIDTH'(4);
        end
    end

    // The live mask backs up the single epoch bit: two redirects before a
    // stale response returns would otherwise alias back to a matching epoch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) ifl_pc[i] <= '0;
            ifl_ep   <= '0;
            ifl_live <= '0;
            ifl_wr   <= '0;
            ifl_rd   <= '0;
            ifl_cnt  <= '0;
        end else begin
            if (kill) ifl_live <= '0;
            if (accept) begin
                ifl_pc[ifl_wr]   <= fetch_pc;
                ifl_ep[ifl_wr]   <= epoch;
                ifl_live[ifl_wr] <= !kill;
                ifl_wr           <= ifl_wr + PW'(1);
            end
            if (rsp_take) ifl_rd <= ifl_rd + PW'(1);
            ifl_cnt <= ifl_cnt + CW'(accept) - CW'(rsp_take);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
            buf_err <= '0;
            buf_wr  <= '0;
            buf_rd  <= '0;
            buf_cnt <= '0;
        end else if (redirect_valid_i) begin
            buf_wr  <= '0;
            buf_rd  <= '0;
            buf_cnt <= '0;
        end else begin
            if (rsp_keep) begin
                buf_instr[buf_wr] <= imem_rsp_err ? NOP : imem_rsp_data;
                buf_pc[buf_wr]    <= head_pc;
                buf_err[buf_wr]   <= imem_rsp_err;
                buf_wr            <= buf_wr + PW'(1);
            end
            if (pop) buf_rd <= buf_rd + PW'(1);
            buf_cnt <= buf_cnt + CW'(rsp_keep) - CW'(pop);
        end
    end
endmodule
